// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared BNN constants, loader state encoding and image helpers
package bnn_pkg;

    localparam int NUM_NEURONS = 4;
    localparam int NUM_WEIGHTS = 6;
    localparam int PTR_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CNT_W       = $clog2(NUM_NEURONS + 1);
    localparam int IMG_W       = NUM_NEURONS * NUM_WEIGHTS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } loader_state_e;

    // Slice neuron idx out of a packed weight image (neuron 0 in the LSBs).
    function automatic logic [NUM_WEIGHTS-1:0] neuron_weight(
        input logic [IMG_W-1:0] img,
        input logic [PTR_W-1:0] idx
    );
        return img[int'(idx) * NUM_WEIGHTS +: NUM_WEIGHTS];
    endfunction

    // Next value of the core's load pointer, wrapping at NUM_NEURONS.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_NEURONS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/bnn_weight_loader.sv
// rtl/bnn_weight_loader.sv - replays a captured weight image into the BNN core load port
module bnn_weight_loader
    import bnn_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IMG_W-1:0]       weights_in,
    input  logic                   ptr_clr,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   load_en,
    output logic [NUM_WEIGHTS-1:0] weight_out,
    output logic [PTR_W-1:0]       ptr
);

    // Value loaded into the gap down-counter; it counts GAP_LOAD..0 inclusive.
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    loader_state_e          state_q, state_d;
    logic [IMG_W-1:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             gap_q, gap_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   load_en_q, load_en_d;
    logic [NUM_WEIGHTS-1:0] weight_q, weight_d;

    // Next-state logic; load_en/weight are precomputed for the state being entered
    // so both outputs come straight from flops during the BEAT cycle.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        ptr_d     = ptr_q;
        load_en_d = 1'b0;
        weight_d  = weight_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = weights_in;
                    cnt_d    = '0;
                    state_d  = BEAT;
                end else if (ptr_clr) begin
                    ptr_d = '0;
                end
            end
            BEAT: begin
                ptr_d = ptr_inc(ptr_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_NEURONS - 1)) begin
                    state_d = DONE;
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = BEAT;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = BEAT;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == BEAT) begin
            load_en_d = 1'b1;
            weight_d  = neuron_weight(shadow_d, ptr_d);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            ptr_q     <= '0;
            load_en_q <= 1'b0;
            weight_q  <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            ptr_q     <= ptr_d;
            load_en_q <= load_en_d;
            weight_q  <= weight_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign load_en    = load_en_q;
    assign weight_out = weight_q;
    assign ptr        = ptr_q;

endmodule

// File: tb/tb_bnn_weight_loader.sv
// tb/tb_bnn_weight_loader.sv - directed self-checking bench for bnn_weight_loader
module tb_bnn_weight_loader;
    import bnn_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             ptr_clr;
    logic [IMG_W-1:0] weights_in;

    logic       d0_ready, d0_busy, d0_done, d0_load_en;
    logic [5:0] d0_weight_out;
    logic [1:0] d0_ptr;
    logic       d2_ready, d2_busy, d2_done, d2_load_en;
    logic [5:0] d2_weight_out;
    logic [1:0] d2_ptr;

    int tests = 0;
    int fails = 0;

    logic [1:0] fval;
    bit         core_set = 1'b0;
    int         core_set_val = 0;
    logic [5:0] core0_mem [4];
    logic [5:0] core2_mem [4];
    int         core0_ptr = 0;
    int         core2_ptr = 0;

    localparam logic [23:0] IMG  = {6'b110011, 6'b001100, 6'b000111, 6'b111000};
    localparam logic [23:0] IMG2 = {6'b101010, 6'b010101, 6'b111111, 6'b000001};

    always #5 clk = ~clk;

    bnn_weight_loader #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .weights_in(weights_in), .ptr_clr(ptr_clr),
        .ready(d0_ready), .busy(d0_busy), .done(d0_done), .load_en(d0_load_en),
        .weight_out(d0_weight_out), .ptr(d0_ptr)
    );

    bnn_weight_loader #(.GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .weights_in(weights_in), .ptr_clr(ptr_clr),
        .ready(d2_ready), .busy(d2_busy), .done(d2_done), .load_en(d2_load_en),
        .weight_out(d2_weight_out), .ptr(d2_ptr)
    );

    // Core-side models: pointer shares the system reset and auto-increments per strobe.
    always @(posedge clk) begin
        if (reset) begin
            core0_ptr <= 0;
            core2_ptr <= 0;
        end else if (core_set) begin
            core0_ptr <= core_set_val;
            core2_ptr <= core_set_val;
        end else begin
            if (d0_load_en) begin
                core0_mem[core0_ptr] <= d0_weight_out;
                core0_ptr <= (core0_ptr + 1) % 4;
            end
            if (d2_load_en) begin
                core2_mem[core2_ptr] <= d2_weight_out;
                core2_ptr <= (core2_ptr + 1) % 4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ptr(input logic [1:0] v);
        fval = v;
        force dut0.ptr_q = fval;
        force dut2.ptr_q = fval;
        core_set = 1'b1;
        core_set_val = int'(v);
        @(negedge clk);
        release dut0.ptr_q;
        release dut2.ptr_q;
        core_set = 1'b0;
        chk("set_ptr_d0", d0_ptr, v);
        chk("set_ptr_d2", d2_ptr, v);
    endtask

    task automatic run_xfer(input logic [23:0] img, input int p0, input bit perturb, input bit clr);
        logic [5:0] w [4];
        int j0, j2;
        for (int k = 0; k < 4; k++) w[k] = img[k*6 +: 6];
        weights_in = img;
        start      = 1'b1;
        ptr_clr    = clr;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start   = 1'b0;
            ptr_clr = 1'b0;
            if (perturb && c == 2) begin
                start      = 1'b1;
                weights_in = '1;
            end
            if (perturb && c == 3) ptr_clr = 1'b1;
            j0 = (c <= 4) ? c - 1 : 3;
            j2 = (c > 10) ? 3 : (c - 1) / 3;
            chk("d0_load_en", d0_load_en, c <= 4);
            chk("d0_weight",  d0_weight_out, w[(p0 + j0) % 4]);
            chk("d0_done",    d0_done, c == 5);
            chk("d0_ready",   d0_ready, c >= 6);
            chk("d0_busy",    d0_busy, c < 6);
            if (c <= 4) chk("d0_ptr_beat", d0_ptr, (p0 + c - 1) % 4);
            chk("d2_load_en", d2_load_en, (c <= 10) && ((c - 1) % 3 == 0));
            chk("d2_weight",  d2_weight_out, w[(p0 + j2) % 4]);
            chk("d2_done",    d2_done, c == 11);
            chk("d2_ready",   d2_ready, c >= 12);
            if (c <= 10 && (c - 1) % 3 == 0) chk("d2_ptr_beat", d2_ptr, (p0 + j2) % 4);
        end
        weights_in = img;
        chk("d0_ptr_end",  d0_ptr, p0);
        chk("d2_ptr_end",  d2_ptr, p0);
        chk("core0_ptr",   core0_ptr, p0);
        chk("core2_ptr",   core2_ptr, p0);
        for (int k = 0; k < 4; k++) begin
            chk("core0_slot", core0_mem[k], w[k]);
            chk("core2_slot", core2_mem[k], w[k]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        ptr_clr    = 1'b0;
        weights_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_d0_ready",   d0_ready, 1'b1);
        chk("rst_d0_busy",    d0_busy, 1'b0);
        chk("rst_d0_done",    d0_done, 1'b0);
        chk("rst_d0_load_en", d0_load_en, 1'b0);
        chk("rst_d0_weight",  d0_weight_out, 6'd0);
        chk("rst_d0_ptr",     d0_ptr, 2'd0);
        chk("rst_d2_ready",   d2_ready, 1'b1);
        chk("rst_d2_load_en", d2_load_en, 1'b0);
        chk("rst_d2_ptr",     d2_ptr, 2'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic transfer, gap pacing and busy-time start/ptr_clr being ignored
        run_xfer(IMG, 0, 1'b1, 1'b0);

        // pointer resync via ptr_clr in IDLE
        set_ptr(2'd2);
        ptr_clr = 1'b1;
        @(negedge clk);
        ptr_clr = 1'b0;
        chk("clr_d0_ptr", d0_ptr, 2'd0);
        chk("clr_d2_ptr", d2_ptr, 2'd0);

        // transfer starting from ptr=2 sends neurons 2,3,0,1
        set_ptr(2'd2);
        run_xfer(IMG2, 2, 1'b0, 1'b0);

        // start and ptr_clr together: start wins, transfer begins at neuron 1
        set_ptr(2'd1);
        run_xfer(IMG, 1, 1'b0, 1'b1);

        // reset in the cycle after beat 2
        weights_in = IMG2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_d0_load_en", d0_load_en, 1'b0);
        chk("mid_rst_d0_ready",   d0_ready, 1'b1);
        chk("mid_rst_d0_ptr",     d0_ptr, 2'd0);
        chk("mid_rst_d0_done",    d0_done, 1'b0);
        chk("mid_rst_d2_load_en", d2_load_en, 1'b0);
        chk("mid_rst_d2_ready",   d2_ready, 1'b1);
        chk("mid_rst_d2_ptr",     d2_ptr, 2'd0);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_d0_done", d0_done, 1'b0);
            chk("post_rst_d2_done", d2_done, 1'b0);
        end
        run_xfer(IMG2, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
